fetch_stage: RTL and testbench
==============================

# fetch_stage

Parametrised instruction-fetch stage that replaces the discrete PC counter plus IF/ID register pairing with a single block. It generates the instruction address for a synchronous (1-cycle-latency) instruction ROM, tags each returned word with its PC, and presents it to decode through an output register with valid, stall and redirect handling. It sits between the instruction ROM and the instruction decoder.

## Interface
- PC_W, 16: PC and instruction-address width.
- INST_W, 26: instruction word width.
- RESET_PC, 0: PC fetched first after reset.
- PC_STEP, 1: PC increment per sequential fetch.
- CNT_W, 32: performance counter width; used only with FETCH_STAGE_PERF_EN.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  PC_W  ROM address; equals pc_q (combinational from register).
- imem_data  in  INST_W  ROM data for the address presented on the previous cycle.
- stall  in  1  decode cannot accept a new instruction this cycle.
- redirect_valid  in  1  branch/jump taken; restart fetch at redirect_pc.
- redirect_pc  in  PC_W  redirect target.
- id_inst  out  INST_W  instruction to decode.
- id_pc  out  PC_W  PC of id_inst.
- id_valid  out  1  id_inst/id_pc hold a real instruction.
- perf_fetched  out  CNT_W  (FETCH_STAGE_PERF_EN only) instructions delivered.
- perf_bubbles  out  CNT_W  (FETCH_STAGE_PERF_EN only) advance cycles with no instruction loaded.

## Operation
- State: pc_q, req_pc_q, req_valid_q (in-flight ROM read), hold_inst/hold_pc/hold_valid (one-entry buffer), id_inst/id_pc/id_valid.
- advance = !stall || !id_valid.
- Priority per edge: rst > redirect_valid > advance/stall.
- Redirect: pc_q <= redirect_pc; req_valid_q, hold_valid, id_valid <= 0 (in-flight and held words discarded); id_inst/id_pc keep old value.
- Advance: id_* <= hold_valid ? hold : {imem_data, req_pc_q}; id_valid <= hold_valid | req_valid_q; hold_valid <= 0; req_pc_q <= pc_q; req_valid_q <= 1; pc_q <= pc_q + PC_STEP.
- Stall (!advance): pc_q, req_pc_q hold; req_valid_q <= 0 (repeated read of same address discarded); if req_valid_q, capture {imem_data, req_pc_q} into hold, hold_valid <= 1; id_* hold.
- Invariant: hold_valid && req_valid_q never both 1 (assertable).
- PC arithmetic modulo 2^PC_W; pc_q wraps from max to (max + PC_STEP) mod 2^PC_W with no flag.
- No instruction dropped or duplicated under any stall pattern without redirect.

## Timing
- Reset values: pc_q = RESET_PC, imem_addr = RESET_PC, id_inst = 0, id_pc = 0, id_valid = 0, all internal valids 0, perf counters 0.
- Startup: edge 1 after rst release issues RESET_PC; edge 2 sets id_valid = 1, id_pc = RESET_PC.
- Throughput: one instruction per cycle with stall low.
- Redirect latency: redirect sampled at edge E0 -> id_valid = 1, id_pc = target at edge E0+2.
- Stall release: held word appears on the release edge; next sequential word on the following edge (no bubble if hold was filled).
- Stall with id_valid = 0 is ignored (output register refills).
- Reset mid-stall or mid-redirect: all valids cleared immediately, restart from RESET_PC.

## Configuration
- FETCH_STAGE_PERF_EN defined: perf_fetched increments on every advance edge loading id_valid = 1; perf_bubbles increments on every advance edge loading id_valid = 0; both wrap modulo 2^CNT_W, cleared by rst, not cleared by redirect.
- Not defined: perf ports and counters absent; functional behaviour identical.

## Test plan
- Reset, ROM model mem[a] = a + 0x100, stall = 0 -> id_pc 0,1,2,3… from edge 2, id_inst = 0x100,0x101,… every cycle.
- Stall held 3 cycles after id_pc = 4 -> id_pc stays 4, then 5,6,7 with no gap or duplicate; hold_valid set exactly once.
- redirect_valid with redirect_pc = 0x20 while id_pc = 6 -> id_valid low 2 cycles, then id_pc = 0x20, 0x21.
- Redirect asserted during stall with hold_valid = 1 -> held word discarded, id_pc = target 2 edges later.
- RESET_PC = 16'hFFFE, PC_STEP = 1 -> id_pc FFFE, FFFF, 0000, 0001.
- With FETCH_STAGE_PERF_EN: 10 cycles free-run then one redirect -> perf_fetched = 9 after startup bubble, perf_bubbles counts startup + 2 redirect bubbles.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage: PC generator for a 1-cycle ROM plus IF/ID register with a one-entry hold buffer; 1 instruction/cycle, 2-cycle redirect.
// Backpressure: stall freezes the PC and parks the in-flight word in hold. Optional counters under FETCH_STAGE_PERF_EN.
module fetch_stage #(
  parameter int unsigned       PC_W     = 16,
  parameter int unsigned       INST_W   = 26,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [PC_W-1:0]   PC_STEP  = PC_W'(1)
`ifdef FETCH_STAGE_PERF_EN
  ,
  parameter int unsigned       CNT_W    = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_valid
`ifdef FETCH_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_fetched,
  output logic [CNT_W-1:0]  perf_bubbles
`endif
);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_word_t;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic            req_valid_q;
  fetch_word_t     hold;
  logic            hold_valid;

  logic            advance;
  fetch_word_t     rom_word;
  fetch_word_t     next_word;

  assign imem_addr = pc_q;
  assign advance   = !stall || !id_valid;
  assign rom_word  = '{inst: imem_data, pc: req_pc_q};
  assign next_word = hold_valid ? hold : rom_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      id_inst     <= '0;
      id_pc       <= '0;
      id_valid    <= 1'b0;
    end else if (redirect_valid) begin
      // Drop everything in flight; id_inst/id_pc keep stale contents under id_valid=0.
      pc_q        <= redirect_pc;
      req_valid_q <= 1'b0;
      hold_valid  <= 1'b0;
      id_valid    <= 1'b0;
    end else if (advance) begin
      id_inst     <= next_word.inst;
      id_pc       <= next_word.pc;
      id_valid    <= hold_valid || req_valid_q;
      hold_valid  <= 1'b0;
      req_pc_q    <= pc_q;
      req_valid_q <= 1'b1;
      pc_q        <= pc_q + PC_STEP;
    end else begin
      // The ROM re-reads the frozen pc_q, which is not req_pc_q's word, so that return is discarded.
      req_valid_q <= 1'b0;
      if (req_valid_q) begin
        hold       <= rom_word;
        hold_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_STAGE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else if (advance) begin
      // A redirect edge with advance high loads id_valid=0, so it counts as a bubble.
      if (!redirect_valid && (hold_valid || req_valid_q))
        perf_fetched <= perf_fetched + CNT_W'(1);
      else
        perf_bubbles <= perf_bubbles + CNT_W'(1);
    end
  end
`endif

  hold_req_exclusive: assert property (@(posedge clk) disable iff (rst) !(hold_valid && req_valid_q));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/hold, redirect, reset, PC wrap, optional perf counters.
module tb_fetch_stage;
  localparam int PC_W   = 16;
  localparam int INST_W = 26;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rst2 = 1'b1;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;

  logic [PC_W-1:0]   imem_addr, imem_addr2;
  logic [INST_W-1:0] imem_data, imem_data2;
  logic [INST_W-1:0] id_inst, id_inst2;
  logic [PC_W-1:0]   id_pc, id_pc2;
  logic              id_valid, id_valid2;
`ifdef FETCH_STAGE_PERF_EN
  logic [31:0]       perf_fetched, perf_bubbles, perf_fetched2, perf_bubbles2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Synchronous ROM models: mem[a] = a + 0x100
  always @(posedge clk) imem_data  <= INST_W'(imem_addr)  + INST_W'(26'h100);
  always @(posedge clk) imem_data2 <= INST_W'(imem_addr2) + INST_W'(26'h100);

  fetch_stage #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(16'h0000), .PC_STEP(16'h0001)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid)
`ifdef FETCH_STAGE_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch_stage #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(16'hFFFE), .PC_STEP(16'h0001)) dut_wrap (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .id_inst(id_inst2), .id_pc(id_pc2), .id_valid(id_valid2)
`ifdef FETCH_STAGE_PERF_EN
    , .perf_fetched(perf_fetched2), .perf_bubbles(perf_bubbles2)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (imem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    n_cmp++; if (id_pc !== 16'h0000) begin n_bad++; $display("FAIL reset_pc: got %h want 0000", id_pc); end
    n_cmp++; if (id_inst !== 26'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", id_inst); end
  endtask

  // Leaves id_pc = 4 valid
  task automatic test_stream();
    rst = 1'b0;
    step();
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL startup_bubble: got %b want 0", id_valid); end
    n_cmp++; if (imem_addr !== 16'h0001) begin n_bad++; $display("FAIL startup_addr: got %h want 0001", imem_addr); end
    for (int k = 0; k <= 4; k++) begin
      step();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 16'(k) || id_inst !== 26'(k + 'h100)) begin
        n_bad++;
        $display("FAIL stream_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, id_valid, id_pc, id_inst, 16'(k), 26'(k + 'h100));
      end
    end
  endtask

  // Three stall edges at id_pc=4, then 5,6 with no gap; leaves id_pc = 6
  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 16'h0004 || dut.hold_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_%0d: got v=%b pc=%h hold=%b want v=1 pc=0004 hold=1",
                 k, id_valid, id_pc, dut.hold_valid);
      end
    end
    stall = 1'b0;
    for (int k = 5; k <= 6; k++) begin
      step();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 16'(k) || id_inst !== 26'(k + 'h100) || dut.hold_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_release_%0d: got v=%b pc=%h inst=%h hold=%b want v=1 pc=%h inst=%h hold=0",
                 k, id_valid, id_pc, id_inst, dut.hold_valid, 16'(k), 26'(k + 'h100));
      end
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0020;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (id_valid !== 1'b0 || id_pc !== 16'h0006) begin n_bad++; $display("FAIL redir_e0: got v=%b pc=%h want v=0 pc=0006", id_valid, id_pc); end
    step();
    n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 16'h0021) begin n_bad++; $display("FAIL redir_e1: got v=%b addr=%h want v=0 addr=0021", id_valid, imem_addr); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 16'h0020 || id_inst !== 26'h120) begin n_bad++; $display("FAIL redir_e2: got v=%b pc=%h inst=%h want v=1 pc=0020 inst=120", id_valid, id_pc, id_inst); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 16'h0021 || id_inst !== 26'h121) begin n_bad++; $display("FAIL redir_e3: got v=%b pc=%h inst=%h want v=1 pc=0021 inst=121", id_valid, id_pc, id_inst); end
  endtask

  // Redirect while hold is full; stall stays high so the refill also exercises "stall ignored when empty"
  task automatic test_redirect_in_stall();
    stall = 1'b1;
    step();
    n_cmp++; if (dut.hold_valid !== 1'b1 || id_pc !== 16'h0021) begin n_bad++; $display("FAIL rs_hold: got hold=%b pc=%h want hold=1 pc=0021", dut.hold_valid, id_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (id_valid !== 1'b0 || dut.hold_valid !== 1'b0) begin n_bad++; $display("FAIL rs_e0: got v=%b hold=%b want v=0 hold=0", id_valid, dut.hold_valid); end
    step();
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rs_e1: got v=%b want 0", id_valid); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 16'h0040 || id_inst !== 26'h140) begin n_bad++; $display("FAIL rs_e2: got v=%b pc=%h inst=%h want v=1 pc=0040 inst=140", id_valid, id_pc, id_inst); end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 16'h0040) begin n_bad++; $display("FAIL rs_stalled: got v=%b pc=%h want v=1 pc=0040", id_valid, id_pc); end
    stall = 1'b0;
    for (int k = 'h41; k <= 'h42; k++) begin
      step();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 16'(k) || id_inst !== 26'(k + 'h100)) begin
        n_bad++;
        $display("FAIL rs_release_%h: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, id_valid, id_pc, id_inst, 16'(k), 26'(k + 'h100));
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 16'h0000 || dut.hold_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid: got v=%b addr=%h hold=%b want v=0 addr=0000 hold=0", id_valid, imem_addr, dut.hold_valid); end
    stall = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 16'h0000 || id_inst !== 26'h100) begin n_bad++; $display("FAIL rst_restart: got v=%b pc=%h inst=%h want v=1 pc=0000 inst=100", id_valid, id_pc, id_inst); end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0]   exp_pc   [4];
    logic [INST_W-1:0] exp_inst [4];
    exp_pc   = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_inst = '{26'h100FE, 26'h100FF, 26'h00100, 26'h00101};
    rst2 = 1'b0;
    step();
    n_cmp++; if (id_valid2 !== 1'b0) begin n_bad++; $display("FAIL wrap_bubble: got %b want 0", id_valid2); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (id_valid2 !== 1'b1 || id_pc2 !== exp_pc[k] || id_inst2 !== exp_inst[k]) begin
        n_bad++;
        $display("FAIL wrap_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, id_valid2, id_pc2, id_inst2, exp_pc[k], exp_inst[k]);
      end
    end
  endtask

`ifdef FETCH_STAGE_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    step();
    n_cmp++; if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0) begin n_bad++; $display("FAIL perf_reset: got f=%0d b=%0d want 0 0", perf_fetched, perf_bubbles); end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) step();
    n_cmp++; if (perf_fetched !== 32'd9 || perf_bubbles !== 32'd1) begin n_bad++; $display("FAIL perf_run: got f=%0d b=%0d want 9 1", perf_fetched, perf_bubbles); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    step();
    redirect_valid = 1'b0;
    step();
    n_cmp++; if (perf_fetched !== 32'd9 || perf_bubbles !== 32'd3) begin n_bad++; $display("FAIL perf_redir: got f=%0d b=%0d want 9 3", perf_fetched, perf_bubbles); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_in_stall();
    test_reset_mid_stall();
    test_wrap();
`ifdef FETCH_STAGE_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
